// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);
  localparam int unsigned HDR_W      = HDR_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  // Little-endian assembly: the newest byte lands at the top and older bytes move down.
  function automatic logic [WORD_W-1:0] shift_in_byte(input logic [WORD_W-1:0] w,
                                                      input logic [BYTE_W-1:0] b);
    return {b, w[WORD_W-1:BYTE_W]};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-lane counter, little-endian word assembly and running XOR checksum.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] csum
);

  logic [LANE_W-1:0] lane_q;
  logic [WORD_W-1:0] sh_q;
  logic [BYTE_W-1:0] acc_q;

  // The word completes in the cycle its last byte is accepted; the top registers it.
  assign word       = shift_in_byte(sh_q, byte_in);
  assign word_valid = byte_en && (lane_q == LANE_W'(WORD_BYTES - 1));
  assign csum       = acc_q;

  // Lane counter wraps every word; accumulator spans the whole image.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      lane_q <= '0;
      sh_q   <= '0;
      acc_q  <= '0;
    end else if (byte_en) begin
      lane_q <= lane_q + LANE_W'(1);
      sh_q   <= word;
      acc_q  <= acc_q ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory and gates CPU start.
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned WL_W = ADDR_W + 1;
  localparam int unsigned CAP  = 32'(1) << ADDR_W;

  localparam logic [2:0] ST_HDR0 = HDR0;
  localparam logic [2:0] ST_HDR1 = HDR1;
  localparam logic [2:0] ST_DATA = DATA;
  localparam logic [2:0] ST_CSUM = CSUM;
  localparam logic [2:0] ST_DONE = DONE;
  localparam logic [2:0] ST_ERR  = ERR;

  logic [2:0]        state_q, state_d;
  logic [7:0]        n_lo_q, n_lo_d;
  logic [WL_W-1:0]   n_q, n_d;
  logic [WL_W-1:0]   wl_d, wl_inc;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              we_d, in_ready_d, cpu_run_d, load_err_d;
  logic              accept, byte_en, clr;
  logic [HDR_W-1:0]  n_full;
  logic              word_valid;
  logic [31:0]       word;
  logic [7:0]        csum;

  assign accept = in_valid && in_ready;
  assign n_full = {in_data, n_lo_q};
  assign wl_inc = words_loaded + WL_W'(1);

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d = state_q;
    n_lo_d  = n_lo_q;
    n_d     = n_q;
    wl_d    = words_loaded;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    we_d    = 1'b0;
    byte_en = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_HDR0: begin
        if (accept) begin
          n_lo_d  = in_data;
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (accept) begin
          n_d = WL_W'(n_full);
          if (17'(n_full) > 17'(CAP)) begin
            state_d = ST_ERR;
          end else if (n_full == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        byte_en = accept;
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = words_loaded[ADDR_W-1:0];
          wdata_d = word;
          wl_d    = wl_inc;
          if (wl_inc == n_q) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (reload) begin
          state_d = ST_HDR0;
          clr     = 1'b1;
          wl_d    = '0;
          n_d     = '0;
          n_lo_d  = '0;
        end
      end
      default: begin
        state_d = ST_HDR0;
      end
    endcase
    in_ready_d = (state_d != ST_DONE) && (state_d != ST_ERR);
    cpu_run_d  = (state_d == ST_DONE);
    load_err_d = (state_d == ST_ERR);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  // Header, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_lo_q       <= '0;
      n_q          <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      in_ready     <= 1'b1;
      cpu_run      <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      n_lo_q       <= n_lo_d;
      n_q          <= n_d;
      words_loaded <= wl_d;
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      imem_wdata   <= wdata_d;
      in_ready     <= in_ready_d;
      cpu_run      <= cpu_run_d;
      load_err     <= load_err_d;
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomised scoreboard bench for imem_stream_loader.
module tb_imem_stream_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CAP    = 256;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  imem_stream_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  wr_t         exp_q[$];
  logic [31:0] img[$];
  int unsigned stall_pct   = 0;
  bit          rnd_reload  = 1'b0;
  bit          hold_reload = 1'b0;
  logic        we_prev     = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      chk("we_one_cycle", 64'(we_prev), 64'(0));
      if (exp_q.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(e.addr));
        chk("wr_data", 64'(imem_wdata), 64'(e.data));
      end
    end
    we_prev = imem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (rnd_reload) reload = 1'($urandom_range(1));
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    if (rnd_reload) reload = 1'($urandom_range(1));
    if (hold_reload) reload = 1'b1;
    while (!in_ready) begin
      if (waited > 50) begin
        fail_now("ready_timeout");
        in_valid = 1'b0;
        reload   = 1'b0;
        return;
      end
      waited++;
      tick();
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    reload   = 1'b0;
  endtask

  // mode 0: correct checksum, 1: send cs_val, 2: corrupt checksum.
  task automatic load(input int unsigned n, input int unsigned mode, input logic [7:0] cs_val,
                      input bit cs_reload);
    logic [7:0] cs;
    logic [7:0] cs_send;
    logic [7:0] b;
    bit         ok;
    cs = 8'h00;
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    if (n > CAP) begin
      chk("hdr_err_load_err", 64'(load_err), 64'(1));
      chk("hdr_err_in_ready", 64'(in_ready), 64'(0));
      chk("hdr_err_cpu_run", 64'(cpu_run), 64'(0));
      return;
    end
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        b  = 8'(img[i] >> (8 * k));
        cs = cs ^ b;
        if (k == 3) exp_q.push_back('{i, img[i]});
        send_byte(b);
      end
      chk("strobe_latency", 64'(imem_we), 64'(1));
      chk("words_loaded_step", 64'(words_loaded), 64'(i + 1));
    end
    chk("cpu_run_before_csum", 64'(cpu_run), 64'(0));
    case (mode)
      1:       cs_send = cs_val;
      2:       cs_send = cs ^ 8'($urandom_range(1, 255));
      default: cs_send = cs;
    endcase
    ok = (cs_send == cs);
    hold_reload = cs_reload;
    send_byte(cs_send);
    hold_reload = 1'b0;
    chk("cpu_run_after_csum", 64'(cpu_run), 64'(ok));
    chk("load_err_after_csum", 64'(load_err), 64'(!ok));
    chk("in_ready_after_csum", 64'(in_ready), 64'(0));
    chk("words_loaded_final", 64'(words_loaded), 64'(n));
    tick();
    chk("cpu_run_held", 64'(cpu_run), 64'(ok));
    chk("load_err_held", 64'(load_err), 64'(!ok));
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_cpu_run", 64'(cpu_run), 64'(0));
    chk("reload_load_err", 64'(load_err), 64'(0));
    chk("reload_in_ready", 64'(in_ready), 64'(1));
    chk("reload_words", 64'(words_loaded), 64'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_imem_we"}, 64'(imem_we), 64'(0));
    chk({tag, "_imem_addr"}, 64'(imem_addr), 64'(0));
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
    chk({tag, "_cpu_run"}, 64'(cpu_run), 64'(0));
    chk({tag, "_load_err"}, 64'(load_err), 64'(0));
    chk({tag, "_words"}, 64'(words_loaded), 64'(0));
  endtask

  task automatic rand_img(input int unsigned n);
    img.delete();
    for (int unsigned i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    check_reset_vals("idle");

    // Two-word reference image with its correct checksum.
    img.delete();
    img.push_back(32'h8C010004);
    img.push_back(32'h00221820);
    load(2, 0, 8'h00, 1'b0);
    do_reload();

    // Same image, checksum 0x00 rejected.
    load(2, 1, 8'h00, 1'b0);
    do_reload();

    // Oversized header.
    load(257, 0, 8'h00, 1'b0);
    do_reload();

    // One word with heavy stalls and ignored reload pulses.
    rand_img(1);
    stall_pct  = 50;
    rnd_reload = 1'b1;
    load(1, 0, 8'h00, 1'b0);
    stall_pct  = 0;
    rnd_reload = 1'b0;
    do_reload();

    // Reset mid-word discards partial state.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    rst_n = 1'b0;
    tick();
    check_reset_vals("mid_rst");
    rst_n = 1'b1;
    rand_img(1);
    load(1, 0, 8'h00, 1'b0);
    do_reload();

    // Empty image; reload coincident with the checksum byte is ignored.
    img.delete();
    load(0, 0, 8'h00, 1'b1);
    do_reload();

    // Random images with occasional corrupted checksums.
    for (int t = 0; t < 5; t++) begin
      int unsigned n;
      n = $urandom_range(1, 12);
      rand_img(n);
      stall_pct = 30;
      load(n, ($urandom_range(3) == 0) ? 2 : 0, 8'h00, 1'b0);
      stall_pct = 0;
      do_reload();
    end

    // Full-capacity image.
    rand_img(CAP);
    load(CAP, 0, 8'h00, 1'b0);
    do_reload();

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
